smj_seq_ctrl: RTL and testbench

Sequential front-end and scheduler for the mahjong hand evaluator. It accepts one 6-bit tile per handshake and buffers five tiles. It then sorts them in place by time-sharing a single compare-and-swap unit over ten cycles, following the fixed 5-layer odd-even transposition schedule. Finally it classifies the sorted hand and presents the 2-bit result on a valid/ready output handshake.

---
 rtl/smj_pkg.sv | 42 ++++
 rtl/smj_cas.sv | 17 +
 rtl/smj_seq_ctrl.sv | 98 +++++++++
 tb/tb_smj_seq_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/smj_pkg.sv
// Shared types, result codes and the compare-swap schedule for the mahjong hand sequencer.
package smj_pkg;

  typedef logic [5:0] tile_t;

  typedef enum logic [1:0] {
    LOAD,
    SORT,
    EVAL,
    OUT
  } state_t;

  localparam logic [1:0] RES_NONE     = 2'b00;
  localparam logic [1:0] RES_INVALID  = 2'b01;
  localparam logic [1:0] RES_SEQ_PAIR = 2'b10;
  localparam logic [1:0] RES_TRI_PAIR = 2'b11;

  localparam int HAND_SIZE  = 5;
  localparam int SORT_STEPS = 10;

  // Five odd-even transposition layers flattened to one pair per cycle.
  localparam logic [2:0] CAS_LO [SORT_STEPS] = '{
    3'd0, 3'd2, 3'd1, 3'd3, 3'd0, 3'd2, 3'd1, 3'd3, 3'd0, 3'd2
  };
  localparam logic [2:0] CAS_HI [SORT_STEPS] = '{
    3'd1, 3'd3, 3'd2, 3'd4, 3'd1, 3'd3, 3'd2, 3'd4, 3'd1, 3'd3
  };

  function automatic logic isHonor(input tile_t t);
    return t[5:4] == 2'b00;
  endfunction

  // Honors only run 1..6, suited tiles 1..8; anything above is malformed.
  function automatic logic isBadTile(input tile_t t);
    return isHonor(t) ? (t[3:0] > 4'd6) : (t[3:0] > 4'd8);
  endfunction

  function automatic tile_t tileInc(input tile_t t);
    return t + 6'd1;
  endfunction

endpackage

// File: rtl/smj_cas.sv
// Combinational compare-and-swap: the smaller unsigned tile leaves on o_lo.
module smj_cas
  import smj_pkg::*;
(
  input  tile_t i_a,
  input  tile_t i_b,
  output tile_t o_lo,
  output tile_t o_hi
);

  logic w_swap;

  assign w_swap = i_a > i_b;
  assign o_lo   = w_swap ? i_b : i_a;
  assign o_hi   = w_swap ? i_a : i_b;

endmodule

// File: rtl/smj_seq_ctrl.sv
// Loads five tiles, sorts them with one shared compare-swap over ten cycles,
// classifies the sorted hand and offers the 2-bit result on a valid/ready port.
module smj_seq_ctrl
  import smj_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_in_valid,
  input  logic [5:0] i_in_tile,
  output logic       o_in_ready,
  output logic       o_out_valid,
  output logic [1:0] o_out_data,
  input  logic       i_out_ready
);

  state_t     r_state;
  logic [2:0] r_cnt;
  logic [3:0] r_step;
  tile_t      r_buf [HAND_SIZE];
  logic [1:0] r_outData;

  logic [2:0] w_loIdx;
  logic [2:0] w_hiIdx;
  tile_t      w_casLo;
  tile_t      w_casHi;

  assign w_loIdx = CAS_LO[r_step];
  assign w_hiIdx = CAS_HI[r_step];

  smj_cas u_cas (
    .i_a  (r_buf[w_loIdx]),
    .i_b  (r_buf[w_hiIdx]),
    .o_lo (w_casLo),
    .o_hi (w_casHi)
  );

  function automatic logic [1:0] classify(input tile_t s0, input tile_t s1, input tile_t s2,
                                          input tile_t s3, input tile_t s4);
    logic anyBad;
    logic seqLow;
    logic seqHigh;
    logic seqMid;
    anyBad  = isBadTile(s0) || isBadTile(s1) || isBadTile(s2) || isBadTile(s3) || isBadTile(s4);
    seqLow  = (s1 == tileInc(s0)) && (s2 == tileInc(s1)) && (s3 == s4) && !isHonor(s0);
    seqHigh = (s0 == s1) && (s3 == tileInc(s2)) && (s4 == tileInc(s3)) && !isHonor(s2);
    seqMid  = (s1 == s3) && (s1 == tileInc(s0)) && (s4 == tileInc(s3)) && !isHonor(s0);
    if (anyBad || (s0 == s4)) return RES_INVALID;
    if (((s0 == s1) && (s2 == s4)) || ((s0 == s2) && (s3 == s4))) return RES_TRI_PAIR;
    if (seqLow || seqHigh || seqMid) return RES_SEQ_PAIR;
    return RES_NONE;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= LOAD;
      r_cnt     <= '0;
      r_step    <= '0;
      r_outData <= RES_NONE;
    end else begin
      unique case (r_state)
        LOAD: begin
          if (i_in_valid) begin
            r_buf[r_cnt] <= i_in_tile;
            if (r_cnt == 3'(HAND_SIZE - 1)) begin
              r_cnt   <= '0;
              r_state <= SORT;
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end
        end
        SORT: begin
          r_buf[w_loIdx] <= w_casLo;
          r_buf[w_hiIdx] <= w_casHi;
          if (r_step == 4'(SORT_STEPS - 1)) begin
            r_step  <= '0;
            r_state <= EVAL;
          end else begin
            r_step <= r_step + 4'd1;
          end
        end
        EVAL: begin
          r_outData <= classify(r_buf[0], r_buf[1], r_buf[2], r_buf[3], r_buf[4]);
          r_state   <= OUT;
        end
        OUT: begin
          if (i_out_ready) r_state <= LOAD;
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  assign o_in_ready  = (r_state == LOAD);
  assign o_out_valid = (r_state == OUT);
  assign o_out_data  = r_outData;

endmodule

// File: tb/tb_smj_seq_ctrl.sv
// Directed bench for smj_seq_ctrl: hand-derived results go into a scoreboard queue
// as each hand is sent and are popped and checked when the result is offered.
module tb_smj_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       inValid;
  logic [5:0] inTile;
  logic       inReady;
  logic       outValid;
  logic [1:0] outData;
  logic       outReady;

  int         testsRun = 0;
  int         testsFailed = 0;
  int         edgeCount = 0;
  int         acceptEdge = 0;
  logic [1:0] expQ [$];

  smj_seq_ctrl dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (inValid),
    .i_in_tile   (inTile),
    .o_in_ready  (inReady),
    .o_out_valid (outValid),
    .o_out_data  (outData),
    .i_out_ready (outReady)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCount++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Hand is packed first-tile-first: tile i sits at bits [6*(4-i) +: 6].
  task automatic applyStimulus(input logic [29:0] hand, input int n, input bit expectResult,
                               input logic [1:0] expected);
    int guard;
    for (int i = 0; i < n; i++) begin
      guard   = 0;
      inValid = 1'b1;
      inTile  = hand[6*(4-i) +: 6];
      while (!inReady && guard < 50) begin
        tick();
        guard++;
      end
      check("inReadyInLoad", 8'(inReady), 8'd1);
      tick();
      acceptEdge = edgeCount;
    end
    inValid = 1'b0;
    if (n == 5) check("inReadyDropsInSort", 8'(inReady), 8'd0);
    if (expectResult) expQ.push_back(expected);
  endtask

  task automatic checkOutput(input string tag, input int holdCycles);
    int         guard;
    logic [1:0] expected;
    guard = 0;
    while (!outValid && guard < 40) begin
      tick();
      guard++;
    end
    check({tag, "_valid"}, 8'(outValid), 8'd1);
    check({tag, "_latency"}, 8'(edgeCount - acceptEdge), 8'd11);
    if (expQ.size() != 0) expected = expQ.pop_front();
    else expected = 2'bxx;
    check({tag, "_data"}, 8'(outData), 8'(expected));
    for (int c = 0; c < holdCycles; c++) begin
      inValid = ~c[0];
      inTile  = 6'h07;
      tick();
      check({tag, "_holdValid"}, 8'(outValid), 8'd1);
      check({tag, "_holdData"}, 8'(outData), 8'(expected));
      check({tag, "_holdInReady"}, 8'(inReady), 8'd0);
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    check({tag, "_releaseInReady"}, 8'(inReady), 8'd1);
    check({tag, "_releaseValid"}, 8'(outValid), 8'd0);
    check({tag, "_releaseData"}, 8'(outData), 8'(expected));
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    inValid  = 1'b0;
    inTile   = 6'h00;
    outReady = 1'b0;
    repeat (2) tick();
    check("resetInReady", 8'(inReady), 8'd1);
    check("resetOutValid", 8'(outValid), 8'd0);
    check("resetOutData", 8'(outData), 8'd0);
    rst = 1'b0;

    applyStimulus({6'h25, 6'h11, 6'h25, 6'h11, 6'h11}, 5, 1'b1, 2'b11);
    checkOutput("triPair", 0);

    applyStimulus({6'h13, 6'h05, 6'h11, 6'h12, 6'h05}, 5, 1'b1, 2'b10);
    checkOutput("seqPair", 0);

    applyStimulus({6'h01, 6'h02, 6'h03, 6'h24, 6'h24}, 5, 1'b1, 2'b00);
    checkOutput("honorSeq", 0);

    applyStimulus({6'h07, 6'h11, 6'h11, 6'h11, 6'h22}, 5, 1'b1, 2'b01);
    checkOutput("badHonor", 0);

    applyStimulus({6'h19, 6'h12, 6'h12, 6'h12, 6'h13}, 5, 1'b1, 2'b01);
    checkOutput("badSuited", 0);

    applyStimulus({6'h22, 6'h22, 6'h22, 6'h22, 6'h22}, 5, 1'b1, 2'b01);
    checkOutput("fiveSame", 0);

    applyStimulus({6'h21, 6'h22, 6'h23, 6'h35, 6'h35}, 5, 1'b1, 2'b10);
    checkOutput("backpressure", 6);

    applyStimulus({6'h31, 6'h31, 6'h31, 6'h32, 6'h32}, 5, 1'b1, 2'b11);
    checkOutput("afterBackpressure", 0);

    // Abort during sort step 4, with in_valid also high on the reset edge.
    applyStimulus({6'h07, 6'h38, 6'h07, 6'h36, 6'h34}, 5, 1'b0, 2'b00);
    repeat (4) tick();
    rst     = 1'b1;
    inValid = 1'b1;
    inTile  = 6'h07;
    tick();
    rst     = 1'b0;
    inValid = 1'b0;
    check("sortAbortInReady", 8'(inReady), 8'd1);
    check("sortAbortOutValid", 8'(outValid), 8'd0);
    check("sortAbortOutData", 8'(outData), 8'd0);
    applyStimulus({6'h14, 6'h15, 6'h16, 6'h16, 6'h16}, 5, 1'b1, 2'b10);
    checkOutput("afterSortAbort", 0);

    // Abort after three tiles; a stale count would splice them into the next hand.
    applyStimulus({6'h07, 6'h07, 6'h07, 6'h00, 6'h00}, 3, 1'b0, 2'b00);
    rst     = 1'b1;
    inValid = 1'b1;
    inTile  = 6'h07;
    tick();
    rst     = 1'b0;
    inValid = 1'b0;
    check("loadAbortInReady", 8'(inReady), 8'd1);
    applyStimulus({6'h25, 6'h11, 6'h25, 6'h11, 6'h11}, 5, 1'b1, 2'b11);
    checkOutput("afterLoadAbort", 0);

    check("scoreboardEmpty", 8'(expQ.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
